// File: rtl/sprite_line_fetcher.sv
// Fetches one sprite row from a synchronous ROM into a line buffer during
// horizontal blanking, then serves registered palette indices during active video.
module sprite_line_fetcher #(
  parameter int          SPR_W           = 100,
  parameter int          SPR_H           = 100,
  parameter int          ADDR_W          = 14,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pixel_index,
  output logic              pixel_opaque,
  output logic              busy
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

  state_t              r_state, w_state_nxt;
  logic [COL_W-1:0]    r_col, w_col_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_row_hit, w_row_hit_nxt;
  logic [9:0]          r_sx, w_sx_nxt;
  logic [3:0]          r_pix_idx;
  logic                r_pix_opq;
  logic [3:0]          r_buf [SPR_W];

  logic                w_wr_en;
  logic [COL_W-1:0]    w_wr_idx;
  logic signed [10:0]  w_dy;
  logic signed [10:0]  w_off;
  logic                w_dy_hit;
  logic                w_off_hit;
  logic [ADDR_W-1:0]   w_base;
  logic [3:0]          w_buf_rd;

  // Both differences are taken as 11-bit signed so rows/columns left of or
  // above the sprite come out negative and are rejected by the sign bit.
  assign w_dy      = $signed({1'b0, line_y}) - $signed({1'b0, sprite_y});
  assign w_dy_hit  = !w_dy[10] && (w_dy[9:0] < 10'(SPR_H));
  assign w_base    = ADDR_W'(w_dy[9:0]) * ADDR_W'(SPR_W);

  assign w_off     = $signed({1'b0, DrawX}) - $signed({1'b0, r_sx});
  assign w_off_hit = !w_off[10] && (w_off[9:0] < 10'(SPR_W));
  assign w_buf_rd  = r_buf[w_off[COL_W-1:0]];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_row_hit <= 1'b0;
      r_sx      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_addr    <= w_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_row_hit <= w_row_hit_nxt;
      r_sx      <= w_sx_nxt;
    end
  end

  // ROM data lags the address by one cycle, so each FETCH cycle stores the
  // word for the previous column; LAST stores the final column.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_addr_nxt    = r_addr;
    w_busy_nxt    = r_busy;
    w_row_hit_nxt = r_row_hit;
    w_sx_nxt      = r_sx;
    w_wr_en       = 1'b0;
    w_wr_idx      = r_col - COL_W'(1);
    if (line_start) begin
      w_sx_nxt      = sprite_x;
      w_row_hit_nxt = 1'b0;
      if (w_dy_hit) begin
        w_state_nxt = FETCH;
        w_col_nxt   = '0;
        w_addr_nxt  = w_base;
        w_busy_nxt  = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          w_wr_en = (r_col != '0);
          if (r_col == COL_W'(SPR_W - 1)) begin
            w_state_nxt = LAST;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
            w_col_nxt  = r_col + COL_W'(1);
          end
        end
        LAST: begin
          w_wr_en       = 1'b1;
          w_wr_idx      = COL_W'(SPR_W - 1);
          w_row_hit_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_idx] <= rom_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix_idx <= TRANSPARENT_IDX;
      r_pix_opq <= 1'b0;
    end else if (r_row_hit && !r_busy && w_off_hit) begin
      r_pix_idx <= w_buf_rd;
      r_pix_opq <= (w_buf_rd != TRANSPARENT_IDX);
    end else begin
      r_pix_idx <= TRANSPARENT_IDX;
      r_pix_opq <= 1'b0;
    end
  end

  assign rom_addr     = r_addr;
  assign busy         = r_busy;
  assign pixel_index  = r_pix_idx;
  assign pixel_opaque = r_pix_opq;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomized bench for sprite_line_fetcher: a ROM array plus a row/column
// reference model predicts every pixel the fetcher should present.
module tb_sprite_line_fetcher;
  localparam int SPR_W  = 100;
  localparam int SPR_H  = 100;
  localparam int ADDR_W = 14;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              line_start;
  logic [9:0]        line_y, DrawX, sprite_x, sprite_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data = 4'h0;
  logic [3:0]        pixel_index;
  logic              pixel_opaque, busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] rom_mem [SPR_W*SPR_H];

  // model state: committed row and pending row from the latest line_start
  bit m_valid;
  int m_sx, m_dy;
  bit p_hit;
  int p_sx, p_dy;

  sprite_line_fetcher #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .TRANSPARENT_IDX(4'h0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .line_y(line_y),
    .DrawX(DrawX), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel_index(pixel_index),
    .pixel_opaque(pixel_opaque), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (int'(rom_addr) < SPR_W*SPR_H) rom_data <= rom_mem[rom_addr];
    else rom_data <= 4'h0;
  end

  function automatic void fill_rom(input int mode);
    for (int a = 0; a < SPR_W*SPR_H; a++) begin
      case (mode)
        0: rom_mem[a] = 4'(a);
        1: rom_mem[a] = ((a % SPR_W) == 3) ? 4'h0 : 4'(a);
        2: rom_mem[a] = 4'($urandom_range(0, 15));
        default: rom_mem[a] = 4'((a % 15) + 1);
      endcase
    end
  endfunction

  function automatic logic [4:0] exp_px(input int x);
    int off;
    logic [3:0] v;
    off = x - m_sx;
    if (m_valid && off >= 0 && off < SPR_W) begin
      v = rom_mem[m_dy*SPR_W + off];
      return {(v != 4'h0), v};
    end
    return 5'b0;
  endfunction

  task automatic start_line(input int ly, input int sx, input int sy);
    line_y     = 10'(ly);
    sprite_x   = 10'(sx);
    sprite_y   = 10'(sy);
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    p_dy    = ly - sy;
    p_sx    = sx;
    p_hit   = (p_dy >= 0 && p_dy < SPR_H);
    m_valid = 1'b0;
  endtask

  task automatic wait_fetch(input string name);
    int cnt;
    int exp_a;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      exp_a = p_dy*SPR_W + ((cnt < SPR_W-1) ? cnt : SPR_W-1);
      checks++;
      if (rom_addr !== ADDR_W'(exp_a)) begin
        errors++;
        $display("FAIL %s_addr cyc %0d: got %0d expected %0d", name, cnt, rom_addr, exp_a);
      end
      if (cnt > 0) begin
        checks++;
        if (pixel_opaque !== 1'b0) begin
          errors++;
          $display("FAIL %s_opq_busy cyc %0d: got %b expected 0", name, cnt, pixel_opaque);
        end
      end
      cnt++;
      @(negedge Clk);
    end
    checks++;
    if (cnt != SPR_W+1) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d expected %0d", name, cnt, SPR_W+1);
    end
    m_valid = p_hit;
    m_sx    = p_sx;
    m_dy    = p_dy;
  endtask

  task automatic check_px(input int x, input string name);
    logic [4:0] e;
    DrawX = 10'(x);
    @(negedge Clk);
    e = exp_px(x);
    checks++;
    if (pixel_index !== e[3:0] || pixel_opaque !== e[4]) begin
      errors++;
      $display("FAIL %s x=%0d: got idx=%h opq=%b expected idx=%h opq=%b",
               name, x, pixel_index, pixel_opaque, e[3:0], e[4]);
    end
  endtask

  task automatic check_fixed(input int x, input logic [3:0] idx, input logic opq, input string name);
    DrawX = 10'(x);
    @(negedge Clk);
    checks++;
    if (pixel_index !== idx || pixel_opaque !== opq) begin
      errors++;
      $display("FAIL %s x=%0d: got idx=%h opq=%b expected idx=%h opq=%b",
               name, x, pixel_index, pixel_opaque, idx, opq);
    end
  endtask

  task automatic sweep(input int lo, input int hi, input int step, input string name);
    for (int x = lo; x <= hi; x += step) check_px(x, name);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; line_start = 1'b0; line_y = '0; DrawX = '0;
    sprite_x = '0; sprite_y = '0;
    m_valid = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (rom_addr !== '0 || pixel_index !== 4'h0 || pixel_opaque !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got addr=%0d idx=%h opq=%b busy=%b expected 0/0/0/0",
               rom_addr, pixel_index, pixel_opaque, busy);
    end
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (rom_addr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got addr=%0d busy=%b expected 0/0", rom_addr, busy);
    end
    sweep(0, 120, 20, "reset_px");
  endtask

  task automatic test_row_fetch();
    fill_rom(0);
    start_line(52, 200, 50);
    wait_fetch("row");
    check_fixed(205, 4'hD, 1'b1, "row_205");
    for (int i = 0; i < 20; i++) check_px($urandom_range(150, 320), "row_rand");
  endtask

  task automatic test_transparency_clip();
    fill_rom(1);
    start_line(52, 620, 50);
    wait_fetch("clip");
    check_fixed(623, 4'h0, 1'b0, "clip_transp");
    check_fixed(619, 4'h0, 1'b0, "clip_left");
    check_fixed(639, 4'hB, 1'b1, "clip_639");
    sweep(600, 1023, 11, "clip_sweep");
  endtask

  task automatic test_miss();
    int ly_tab [2] = '{49, 150};
    logic [ADDR_W-1:0] a0;
    int bad;
    fill_rom(3);
    foreach (ly_tab[k]) begin
      a0 = rom_addr;
      start_line(ly_tab[k], 100, 50);
      bad = 0;
      for (int c = 0; c < 110; c++) begin
        if (busy !== 1'b0 || rom_addr !== a0) bad++;
        @(negedge Clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL miss_busy_addr ly=%0d: got %0d bad cycles expected 0", ly_tab[k], bad);
      end
      sweep(0, 639, 13, "miss_px");
    end
  endtask

  task automatic test_restart();
    fill_rom(2);
    DrawX = 10'd150;
    start_line(52, 100, 50);
    repeat (40) @(negedge Clk);
    start_line(60, 100, 50);
    checks++;
    if (rom_addr !== ADDR_W'(1000) || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_jump: got addr=%0d busy=%b expected 1000/1", rom_addr, busy);
    end
    wait_fetch("restart");
    sweep(90, 210, 3, "restart_px");
  endtask

  task automatic test_last_collision();
    fill_rom(3);
    start_line(52, 100, 50);
    repeat (SPR_W) @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL last_busy: got %b expected 1", busy);
    end
    start_line(10, 100, 50);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL last_miss_busy: got %b expected 0", busy);
    end
    sweep(95, 205, 5, "last_discard");
    start_line(52, 100, 50);
    repeat (SPR_W) @(negedge Clk);
    start_line(55, 100, 50);
    wait_fetch("last_hit");
    sweep(95, 205, 5, "last_hit_px");
  endtask

  task automatic test_no_tearing();
    fill_rom(2);
    start_line(70, 300, 50);
    wait_fetch("tear");
    sprite_x = 10'd0;
    sprite_y = 10'd0;
    line_y   = 10'd5;
    sweep(0, 420, 7, "tear_px");
  endtask

  task automatic test_reset_mid();
    fill_rom(3);
    DrawX = 10'd150;
    start_line(52, 100, 50);
    repeat (30) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rom_addr !== '0 || pixel_opaque !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got busy=%b addr=%0d opq=%b expected 0/0/0",
               busy, rom_addr, pixel_opaque);
    end
    m_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    sweep(80, 220, 4, "rstmid_px");
    start_line(52, 100, 50);
    wait_fetch("rstmid_refetch");
    sweep(95, 205, 5, "rstmid_refetch_px");
  endtask

  task automatic test_random();
    int sx, sy, ly, x, bad;
    fill_rom(2);
    for (int n = 0; n < 8; n++) begin
      sx = $urandom_range(0, 639);
      sy = $urandom_range(0, 479);
      if ($urandom_range(0, 3) != 0) ly = sy + $urandom_range(0, SPR_H-1);
      else ly = $urandom_range(0, 1023);
      start_line(ly, sx, sy);
      if (p_hit) begin
        wait_fetch("rand");
      end else begin
        bad = 0;
        for (int c = 0; c < 5; c++) begin
          if (busy !== 1'b0) bad++;
          @(negedge Clk);
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand_miss_busy: got %0d busy cycles expected 0", bad);
        end
      end
      for (int i = 0; i < 30; i++) begin
        x = sx - 20 + $urandom_range(0, 140);
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        check_px(x, "rand_px");
      end
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_row_fetch();
    test_transparency_clip();
    test_miss();
    test_restart();
    test_last_collision();
    test_no_tearing();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
